inst_rom_loader: RTL and testbench

//  Boot-time instruction memory that feeds the CPU core's fetch port (rom_addr/rom_ce/rom_data).

---
 rtl/inst_rom_loader.sv | 162 ++++++++++++++++
 tb/tb_inst_rom_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Boot ROM: loads 32-bit words from a byte stream, holds the core in reset, then serves fetches.
// Latency: fetch read is combinational; cpu_rst_o drops on the edge that ends the load.
// Backpressure: byte_ready is high only while a load needs bytes. INST_ROM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              cpu_rst_o,
    output logic              load_done,
    output logic              load_err
);

`ifdef INST_ROM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHK, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [31:0]       mem [2**ADDR_W];

    state_t            state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shift_q;
    logic              byte_ready_q;
    logic              cpu_rst_q;
    logic              load_done_q;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic              load_err_q;
    logic [7:0]        chk_total;
    assign chk_total = sum_q + byte_data;
`endif

    logic [ADDR_W:0]   len_sat;
    logic              accept;
    logic              word_wr;
    logic              last_word;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_hit;

    assign len_sat   = load_len[ADDR_W] ? MAX_LEN : load_len;
    // A restart edge never consumes a byte, even though byte_ready may still read 1.
    assign accept    = byte_valid & byte_ready_q & ~load_start;
    assign word_wr   = accept && (state_q == S_LOAD) && (byte_cnt_q == 2'd3);
    assign last_word = ((word_cnt_q + ONE) == len_q);

    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[word_cnt_q[ADDR_W-1:0]] <= {shift_q, byte_data};
        end
    end

    assign rd_idx     = rom_addr_i[ADDR_W+1:2];
    assign rd_hit     = rom_ce_i && (state_q == S_RUN) && ({1'b0, rd_idx} < len_q);
    assign rom_data_o = rd_hit ? mem[rd_idx] : 32'h0;

    wire unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            load_err_q   <= 1'b0;
`endif
        end else if (load_start) begin
            len_q        <= len_sat;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            load_done_q  <= 1'b0;
            cpu_rst_q    <= 1'b1;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            load_err_q   <= 1'b0;
            state_q      <= (len_sat == '0) ? S_CHK : S_LOAD;
            byte_ready_q <= 1'b1;
`else
            if (len_sat == '0) begin
                state_q      <= S_RUN;
                byte_ready_q <= 1'b0;
                cpu_rst_q    <= 1'b0;
                load_done_q  <= 1'b1;
            end else begin
                state_q      <= S_LOAD;
                byte_ready_q <= 1'b1;
            end
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        shift_q    <= {shift_q[15:0], byte_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                        sum_q      <= sum_q + byte_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            word_cnt_q <= word_cnt_q + ONE;
                            if (last_word) begin
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                                state_q      <= S_CHK;
`else
                                state_q      <= S_RUN;
                                byte_ready_q <= 1'b0;
                                cpu_rst_q    <= 1'b0;
                                load_done_q  <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        byte_ready_q <= 1'b0;
                        if (chk_total == 8'h00) begin
                            state_q     <= S_RUN;
                            cpu_rst_q   <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign load_done  = load_done_q;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    assign load_err   = load_err_q;
`else
    assign load_err   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: load streams, fetch guards, restart, reset and checksum.
module tb_inst_rom_loader;
    localparam int ADDR_W = 10;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              cpu_rst_o;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .cpu_rst_o  (cpu_rst_o),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    int total  = 0;
    int passed = 0;
    int rel_cnt = 0;
    logic [7:0] stream_q[$];

    always @(negedge cpu_rst_o) rel_cnt++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [ADDR_W:0] n);
        load_start = 1'b1;
        load_len   = n;
        tick();
        load_start = 1'b0;
    endtask

    task automatic rd(input logic ce, input logic [31:0] addr, output logic [31:0] d);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1;
        d = rom_data_o;
    endtask

    // held reports whether the core stayed in reset up to the final byte.
    task automatic send_stream(input bit gaps, input bit add_chk, output bit held);
        logic [7:0] sum;
        bit         acc;
        int         n;
        sum = 8'h00;
        foreach (stream_q[i]) sum = sum + stream_q[i];
        if (add_chk && CHK_EN) stream_q.push_back(8'h00 - sum);
        held = 1'b1;
        n = stream_q.size();
        foreach (stream_q[i]) begin
            if (gaps) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            byte_valid = 1'b1;
            byte_data  = stream_q[i];
            acc = 1'b0;
            for (int w = 0; w < 20 && !acc; w++) begin
                acc = byte_ready;
                tick();
            end
            byte_valid = 1'b0;
            if (!acc) check("byte_timeout", 32'd0, 32'd1);
            if (i < n - 1 && cpu_rst_o !== 1'b1) held = 1'b0;
        end
        stream_q.delete();
    endtask

    task automatic push_t2();
        stream_q = '{8'h34, 8'h02, 8'h00, 8'h05, 8'h34, 8'h03, 8'h00, 8'h07};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rd_vec_t    vt[10];
        logic [31:0] d;
        bit         held;
        int         rc0;

        vt[0] = '{1'b1, 32'h0000_0000, 32'h3402_0005};
        vt[1] = '{1'b1, 32'h0000_0004, 32'h3403_0007};
        vt[2] = '{1'b1, 32'h0000_0007, 32'h3403_0007};
        vt[3] = '{1'b1, 32'h0000_0002, 32'h3402_0005};
        vt[4] = '{1'b1, 32'h0000_0008, 32'h0000_0000};
        vt[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
        vt[6] = '{1'b1, 32'h1000_0004, 32'h3403_0007};
        vt[7] = '{1'b1, 32'h0000_1000, 32'h3402_0005};
        vt[8] = '{1'b1, 32'h0000_0FFC, 32'h0000_0000};
        vt[9] = '{1'b0, 32'h0000_0004, 32'h0000_0000};

        rst = 1'b1; load_start = 1'b0; load_len = '0;
        byte_valid = 1'b0; byte_data = '0; rom_ce_i = 1'b0; rom_addr_i = '0;
        #2 rst = 1'b0;
        #10;
        check("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        tick();
        rst = 1'b1;
        byte_valid = 1'b1; byte_data = 8'hEE;
        repeat (2) tick();
        byte_valid = 1'b0;
        check("idle_ignores_bytes", {30'd0, byte_ready, cpu_rst_o}, 32'd1);

        // T2: basic two-word load
        start_load(11'd2);
        check("t2_ready_after_start", {31'd0, byte_ready}, 32'd1);
        push_t2();
        send_stream(1'b0, 1'b1, held);
        check("t2_held_until_last", {31'd0, held}, 32'd1);
        check("t2_cpu_released", {31'd0, cpu_rst_o}, 32'd0);
        check("t2_load_done", {31'd0, load_done}, 32'd1);
        check("t2_ready_low", {31'd0, byte_ready}, 32'd0);
        check("t2_no_err", {31'd0, load_err}, 32'd0);

        // T3: fetch guards and aliasing
        for (int i = 0; i < 10; i++) begin
            rd(vt[i].ce, vt[i].addr, d);
            check($sformatf("t3_read%0d", i), d, vt[i].exp);
        end
        tick();

        // T1: reset in RUN drops everything immediately
        rom_ce_i = 1'b1; rom_addr_i = 32'h0;
        rst = 1'b0;
        #1;
        check("t1_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("t1_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("t1_load_done", {31'd0, load_done}, 32'd0);
        check("t1_rom_data", rom_data_o, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Overwrite RAM so the backpressured reload has something to prove
        start_load(11'd2);
        stream_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88};
        send_stream(1'b0, 1'b1, held);
        rd(1'b1, 32'h0, d);
        check("scramble_w0", d, 32'hAABB_CCDD);
        rd(1'b1, 32'h4, d);
        check("scramble_w1", d, 32'h5566_7788);
        tick();

        // T4: T2 stream with random valid gaps
        start_load(11'd2);
        push_t2();
        send_stream(1'b1, 1'b1, held);
        check("t4_held", {31'd0, held}, 32'd1);
        check("t4_done", {31'd0, load_done}, 32'd1);
        rd(1'b1, 32'h0, d);
        check("t4_w0", d, 32'h3402_0005);
        rd(1'b1, 32'h4, d);
        check("t4_w1", d, 32'h3403_0007);
        tick();

        // T5: restart mid-load, with a byte offered on the restart edge
        rc0 = rel_cnt;
        start_load(11'd2);
        stream_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_stream(1'b0, 1'b0, held);
        check("t5_still_reset", {31'd0, cpu_rst_o}, 32'd1);
        byte_valid = 1'b1; byte_data = 8'h99;
        start_load(11'd1);
        byte_valid = 1'b0;
        check("t5_restart_state", {29'd0, cpu_rst_o, load_done, byte_ready}, 32'b101);
        stream_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(1'b0, 1'b1, held);
        check("t5_release_once", rel_cnt - rc0, 32'd1);
        rd(1'b1, 32'h0, d);
        check("t5_w0", d, 32'h1122_3344);
        rd(1'b1, 32'h4, d);
        check("t5_beyond_len", d, 32'h0);
        tick();

        // Zero-length load
        start_load(11'd0);
        send_stream(1'b0, 1'b1, held);
        check("len0_state", {29'd0, cpu_rst_o, load_done, byte_ready}, 32'b010);
        rd(1'b1, 32'h0, d);
        check("len0_read", d, 32'h0);
        tick();

        // Oversized length clamps to the full 1024-word RAM
        start_load(11'h7FF);
        for (int i = 0; i < 4096; i++) stream_q.push_back(8'(i));
        send_stream(1'b0, 1'b1, held);
        check("clamp_held", {31'd0, held}, 32'd1);
        check("clamp_done", {31'd0, load_done}, 32'd1);
        rd(1'b1, 32'h0000_0FFC, d);
        check("clamp_last", d, 32'hFCFD_FEFF);
        rd(1'b1, 32'h0000_0000, d);
        check("clamp_first", d, 32'h0001_0203);
        tick();

`ifdef INST_ROM_LOADER_CHECKSUM_EN
        // T6: good and bad checksum
        start_load(11'd1);
        stream_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        send_stream(1'b0, 1'b0, held);
        check("t6_good", {29'd0, cpu_rst_o, load_done, load_err}, 32'b010);
        start_load(11'd1);
        stream_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
        send_stream(1'b0, 1'b0, held);
        check("t6_bad", {28'd0, cpu_rst_o, load_done, load_err, byte_ready}, 32'b1010);
        tick();
        check("t6_err_sticky", {31'd0, load_err}, 32'd1);
        start_load(11'd1);
        check("t6_err_cleared", {30'd0, load_err, byte_ready}, 32'b01);
        tick();
`else
        check("no_chk_err_low", {31'd0, load_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
